seq_det_ctrl: RTL and testbench
===============================

Name: seq_det_ctrl

Overview:
Run controller for the serial bit-pattern detector datapath.
- Accepts a pattern configuration through a ready/valid handshake, then arms on `start`.
- Searches the qualified serial stream `din`/`din_valid` for the pattern and counts hits until a target count is reached.
- Reports timeout if no hit arrives within a programmable window; `abort` cancels a run.
- Sits between the register/config layer and the serial input path; replaces hard-coded per-pattern Moore FSMs with one programmable engine.

Parameters:
PAT_MAX, 8, maximum pattern length in bits (2..16)
LEN_W, $clog2(PAT_MAX+1), width of length field
CNT_W, 8, width of hit target and hit counter
TMO_W, 16, width of timeout window counter

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
cfg_valid  in  1  config offer
cfg_ready  out  1  config accepted when valid&ready; high only in IDLE
cfg_pattern  in  PAT_MAX  pattern bits; bit [len-1] is received first
cfg_len  in  LEN_W  pattern length; 0 or 1 clamps to 2, >PAT_MAX clamps to PAT_MAX
cfg_target  in  CNT_W  hits required to finish; 0 treated as 1
cfg_timeout  in  TMO_W  max cycles between arm/hit and next hit; 0 = disabled
start  in  1  arm request (one-cycle pulse)
abort  in  1  cancel run, back to IDLE
din  in  1  serial data
din_valid  in  1  din qualifier
busy  out  1  high in ARMED
match_pulse  out  1  one-cycle pulse per detected hit
match_cnt  out  CNT_W  hits in current run
done  out  1  sticky, target reached
timeout  out  1  sticky, window expired

Behaviour:
- Reset: state IDLE.
  - All outputs 0 except `cfg_ready`=1.
  - Config registers: pattern 0, len 2, target 1, timeout 0.
  - History and fill count 0.
- States: IDLE, ARMED, DONE, TMO. One-hot encoding. Illegal state -> IDLE.
- IDLE:
  - cfg handshake latches all cfg_* fields; `cfg_ready` stays high.
  - `start` -> ARMED. Clears `match_cnt`, history, fill, window counter, `done`, `timeout`.
  - cfg_valid and start in the same cycle: config latched, and the run uses the new config.
- ARMED, on each `din_valid`:
  - Shift `din` into the LSB of the history register.
  - Fill saturates at len.
  - Hit when fill (post-increment) >= len and history[len-1:0]==pattern[len-1:0].
- Latency: hit on sample edge k -> `match_pulse` high cycle k+1, `match_cnt` incremented at the same edge (registered Moore outputs).
- Hit count:
  - Non-overlap (default): after a hit, fill resets to 0 and history is kept; the next hit needs len fresh bits.
  - Hit making `match_cnt`==target: `done`=1, state DONE, same edge as `match_pulse`. `match_cnt` saturates at target.
- Window counter:
  - Increments every ARMED cycle (independent of `din_valid`); cleared on each hit.
  - Reaching `cfg_timeout` (nonzero) -> `timeout`=1, state TMO.
  - Hit and expiry on the same edge: hit wins.
- DONE/TMO:
  - `din` is ignored; `cfg_ready`=0.
  - `start` re-arms with the latched config. `abort` -> IDLE; sticky flags cleared.
- `abort` has priority over all events in any state. In ARMED it returns to IDLE with `match_cnt` held and no pulse.
- `start` while ARMED is ignored. `din_valid` low means no shift and no fill change.
- Async reset mid-run returns everything to reset values immediately.

Optional Feature:
`SEQ_DET_OVERLAP_EN`
- Defined: overlapping hits. Fill is not cleared on a hit, so a pattern suffix can start the next hit.
- Undefined: non-overlap behaviour as above. No other difference.

Decomposition:
- Package `seq_det_pkg`:
  - state enum and one-hot constants
  - default PAT_MAX/CNT_W/TMO_W
  - clamp helper function for len/target
- One sub-module `seq_det_core`: history shift register, fill counter, masked compare, hit output.
- `seq_det_ctrl` keeps the FSM, config registers, counters and outputs.

Test Plan:
1. Reset, then cfg pattern=8'b0001_0111 len=5 target=1 timeout=0, start, stream 1,0,1,1,1 -> `match_pulse` one cycle after 5th valid sample; `match_cnt`=1; `done`=1; state DONE.
2. Same config, target=2, stream 1,0,1,1,1,0,1,1,1 -> non-overlap: one hit, `done`=0. With `SEQ_DET_OVERLAP_EN`: hits at samples 5 and 9, `done`=1.
3. len=3 pattern=101, target=3, timeout=20, stream 101 then 25 idle cycles -> `match_cnt`=1, `timeout`=1 at cycle 20 after the hit, state TMO.
4. Hit on the same edge as window expiry (timeout=6, 6th cycle hit) -> `match_cnt` increments, `timeout` stays 0.
5. Mid-run `abort` with `din_valid` gaps, then cfg_valid and start together with len=0 -> len clamps to 2; `cfg_ready` 1 in IDLE only; new run uses new pattern.
6. Assert rst_n low during ARMED after 3 of 5 bits -> all outputs reset immediately; after release, 2 more bits give no hit.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared constants, one-hot state encoding and the config clamp helper
// for the programmable serial sequence detector.
package seq_det_pkg;

    localparam int PAT_MAX_DEF = 8;
    localparam int CNT_W_DEF   = 8;
    localparam int TMO_W_DEF   = 16;

    typedef enum int {
        IDX_IDLE  = 0,
        IDX_ARMED = 1,
        IDX_DONE  = 2,
        IDX_TMO   = 3
    } state_idx_e;

    localparam logic [3:0] ST_IDLE  = 4'(1 << IDX_IDLE);
    localparam logic [3:0] ST_ARMED = 4'(1 << IDX_ARMED);
    localparam logic [3:0] ST_DONE  = 4'(1 << IDX_DONE);
    localparam logic [3:0] ST_TMO   = 4'(1 << IDX_TMO);

    function automatic int clamp_range(input int value, input int lo, input int hi);
        if (value < lo) return lo;
        if (value > hi) return hi;
        return value;
    endfunction

endpackage

// File: rtl/seq_det_core.sv
// History shift register, fill counter and masked pattern compare.
// Define SEQ_DET_OVERLAP_EN to keep the fill count across hits (overlapping matches).
module seq_det_core #(
    parameter int PAT_MAX = 8,
    parameter int LEN_W   = $clog2(PAT_MAX + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               shift_en,
    input  logic               din,
    input  logic [PAT_MAX-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    output logic               hit
);

    logic [PAT_MAX-1:0] hist_q, hist_d, hist_shift, mask;
    logic [LEN_W-1:0]   fill_q, fill_d, fill_inc;

    always_comb begin
        for (int i = 0; i < PAT_MAX; i++) begin
            mask[i] = (i < int'(len));
        end
    end

    always_comb begin
        hist_shift = {hist_q[PAT_MAX-2:0], din};
        fill_inc   = (fill_q < len) ? fill_q + LEN_W'(1) : len;
        hit        = shift_en && (fill_inc >= len) &&
                     ((hist_shift & mask) == (pattern & mask));
        hist_d     = hist_q;
        fill_d     = fill_q;
        if (clear) begin
            hist_d = '0;
            fill_d = '0;
        end else if (shift_en) begin
            hist_d = hist_shift;
`ifdef SEQ_DET_OVERLAP_EN
            fill_d = fill_inc;
`else
            // History survives a hit; only the fill restarts, so the next hit needs len new bits.
            fill_d = hit ? '0 : fill_inc;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// Run controller: config handshake, one-hot run FSM, hit/window counters and sticky flags.
// Overlapping hits are enabled by defining SEQ_DET_OVERLAP_EN (handled in seq_det_core).
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int PAT_MAX = PAT_MAX_DEF,
    parameter int LEN_W   = $clog2(PAT_MAX + 1),
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TMO_W   = TMO_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [PAT_MAX-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic [CNT_W-1:0]   cfg_target,
    input  logic [TMO_W-1:0]   cfg_timeout,
    input  logic               start,
    input  logic               abort,
    input  logic               din,
    input  logic               din_valid,
    output logic               busy,
    output logic               match_pulse,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               done,
    output logic               timeout
);

    localparam int TGT_MAX = (1 << CNT_W) - 1;

    logic [3:0]         state_q, state_d;
    logic [PAT_MAX-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   tgt_q, tgt_d, cnt_q, cnt_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d, win_q, win_d, win_inc;
    logic               match_q, match_d, done_q, done_d, tmo_flag_q, tmo_flag_d;
    logic               cfg_fire, arm, shift_en, hit;

    assign cfg_ready = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_ARMED);
    assign cfg_fire  = cfg_valid && cfg_ready;
    assign arm       = start && !abort &&
                       (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_TMO);
    assign shift_en  = busy && din_valid && !abort;

    seq_det_core #(
        .PAT_MAX (PAT_MAX),
        .LEN_W   (LEN_W)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (arm),
        .shift_en (shift_en),
        .din      (din),
        .pattern  (pat_q),
        .len      (len_q),
        .hit      (hit)
    );

    always_comb begin
        pat_d = pat_q;
        len_d = len_q;
        tgt_d = tgt_q;
        tmo_d = tmo_q;
        if (cfg_fire) begin
            pat_d = cfg_pattern;
            len_d = LEN_W'(clamp_range(int'(cfg_len), 2, PAT_MAX));
            tgt_d = CNT_W'(clamp_range(int'(cfg_target), 1, TGT_MAX));
            tmo_d = cfg_timeout;
        end
    end

    // Abort overrides everything; a hit beats window expiry on the same edge.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        win_d      = win_q;
        match_d    = 1'b0;
        done_d     = done_q;
        tmo_flag_d = tmo_flag_q;
        win_inc    = win_q + TMO_W'(1);
        if (abort) begin
            state_d    = ST_IDLE;
            done_d     = 1'b0;
            tmo_flag_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_TMO: begin
                    if (arm) begin
                        state_d    = ST_ARMED;
                        cnt_d      = '0;
                        win_d      = '0;
                        done_d     = 1'b0;
                        tmo_flag_d = 1'b0;
                    end
                end
                ST_ARMED: begin
                    if (hit) begin
                        match_d = 1'b1;
                        win_d   = '0;
                        if (cnt_q < tgt_q) cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q + CNT_W'(1) >= tgt_q) begin
                            done_d  = 1'b1;
                            state_d = ST_DONE;
                        end
                    end else begin
                        win_d = win_inc;
                        if (tmo_q != '0 && win_inc == tmo_q) begin
                            tmo_flag_d = 1'b1;
                            state_d    = ST_TMO;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pat_q      <= '0;
            len_q      <= LEN_W'(2);
            tgt_q      <= CNT_W'(1);
            tmo_q      <= '0;
            cnt_q      <= '0;
            win_q      <= '0;
            match_q    <= 1'b0;
            done_q     <= 1'b0;
            tmo_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pat_q      <= pat_d;
            len_q      <= len_d;
            tgt_q      <= tgt_d;
            tmo_q      <= tmo_d;
            cnt_q      <= cnt_d;
            win_q      <= win_d;
            match_q    <= match_d;
            done_q     <= done_d;
            tmo_flag_q <= tmo_flag_d;
        end
    end

    assign match_pulse = match_q;
    assign match_cnt   = cnt_q;
    assign done        = done_q;
    assign timeout     = tmo_flag_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Self-checking bench for seq_det_ctrl: vector table, directed corner cases and
// randomized traffic against a bit-queue reference model (SEQ_DET_OVERLAP_EN aware).
module tb_seq_det_ctrl;

`ifdef SEQ_DET_OVERLAP_EN
    localparam bit OVERLAP = 1'b1;
`else
    localparam bit OVERLAP = 1'b0;
`endif

    localparam int M_IDLE = 0, M_ARMED = 1, M_DONE = 2, M_TMO = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_valid, cfg_ready;
    logic [7:0]  cfg_pattern;
    logic [3:0]  cfg_len;
    logic [7:0]  cfg_target;
    logic [15:0] cfg_timeout;
    logic        start, abort, din, din_valid;
    logic        busy, match_pulse, done, timeout;
    logic [7:0]  match_cnt;

    int assertCount = 0;
    int failCount   = 0;

    // Reference model state: the bits seen since arm (or since the last hit without overlap)
    int     m_state, m_len, m_tgt, m_tmo, m_cnt, m_win;
    bit [7:0] m_pat;
    bit     m_pulse, m_done, m_to;
    bit     bits_q[$];

    typedef struct {
        logic       cv;
        logic       st;
        logic       ab;
        logic       d;
        logic       dv;
        logic       exp_pulse;
        logic [7:0] exp_cnt;
        logic       exp_done;
        logic       exp_to;
        logic       exp_busy;
        logic       exp_ready;
    } vec_t;

    vec_t vecs[9];

    seq_det_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_target  (cfg_target),
        .cfg_timeout (cfg_timeout),
        .start       (start),
        .abort       (abort),
        .din         (din),
        .din_valid   (din_valid),
        .busy        (busy),
        .match_pulse (match_pulse),
        .match_cnt   (match_cnt),
        .done        (done),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    function automatic vec_t mkVec(bit cv, bit st, bit ab, bit d, bit dv,
                                   bit ep, int ec, bit ed, bit et, bit eb, bit er);
        vec_t v;
        v.cv = cv; v.st = st; v.ab = ab; v.d = d; v.dv = dv;
        v.exp_pulse = ep; v.exp_cnt = 8'(ec); v.exp_done = ed;
        v.exp_to = et; v.exp_busy = eb; v.exp_ready = er;
        return v;
    endfunction

    function automatic void model_reset();
        m_state = M_IDLE; m_pat = '0; m_len = 2; m_tgt = 1; m_tmo = 0;
        m_cnt = 0; m_win = 0; m_pulse = 0; m_done = 0; m_to = 0;
        bits_q.delete();
    endfunction

    function automatic void model_step();
        bit hit;
        m_pulse = 0;
        if (cfg_valid && m_state == M_IDLE) begin
            m_pat = cfg_pattern;
            m_len = (cfg_len < 2) ? 2 : ((cfg_len > 8) ? 8 : int'(cfg_len));
            m_tgt = (cfg_target == 0) ? 1 : int'(cfg_target);
            m_tmo = int'(cfg_timeout);
        end
        if (abort) begin
            m_state = M_IDLE; m_done = 0; m_to = 0;
            return;
        end
        if (m_state != M_ARMED) begin
            if (start) begin
                m_state = M_ARMED; m_cnt = 0; m_win = 0; m_done = 0; m_to = 0;
                bits_q.delete();
            end
            return;
        end
        hit = 0;
        if (din_valid) begin
            bits_q.push_back(din);
            if (bits_q.size() > 16) void'(bits_q.pop_front());
            if (bits_q.size() >= m_len) begin
                hit = 1;
                for (int i = 0; i < m_len; i++)
                    if (bits_q[bits_q.size() - 1 - i] != m_pat[i]) hit = 0;
            end
        end
        if (hit) begin
            m_pulse = 1; m_cnt++; m_win = 0;
            if (!OVERLAP) bits_q.delete();
            if (m_cnt >= m_tgt) begin m_done = 1; m_state = M_DONE; end
        end else begin
            m_win++;
            if (m_tmo != 0 && m_win == m_tmo) begin m_to = 1; m_state = M_TMO; end
        end
    endfunction

    task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, ".pulse"}, 32'(match_pulse), 32'(m_pulse));
        checkValue({tag, ".cnt"},   32'(match_cnt),   32'(m_cnt));
        checkValue({tag, ".done"},  32'(done),        32'(m_done));
        checkValue({tag, ".tmo"},   32'(timeout),     32'(m_to));
        checkValue({tag, ".busy"},  32'(busy),        32'(m_state == M_ARMED));
        checkValue({tag, ".ready"}, 32'(cfg_ready),   32'(m_state == M_IDLE));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        checkOutput(tag);
    endtask

    task automatic applyStimulus(input vec_t v, input string tag);
        cfg_valid = v.cv; start = v.st; abort = v.ab; din = v.d; din_valid = v.dv;
        tick(tag);
        cfg_valid = 0; start = 0; abort = 0; din_valid = 0;
    endtask

    task automatic configure(input logic [7:0] p, input logic [3:0] l, input logic [7:0] t,
                             input logic [15:0] to, input bit with_start);
        cfg_pattern = p; cfg_len = l; cfg_target = t; cfg_timeout = to;
        cfg_valid = 1; start = with_start;
        tick("cfg");
        cfg_valid = 0; start = 0;
    endtask

    task automatic arm();
        start = 1; tick("arm"); start = 0;
    endtask

    task automatic doAbort();
        abort = 1; tick("abort"); abort = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick("idle");
    endtask

    task automatic sendBits(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            din = bits[i]; din_valid = 1;
            tick("bit");
            din_valid = 0;
        end
    endtask

    initial begin
        rst_n = 0; cfg_valid = 0; cfg_pattern = '0; cfg_len = '0; cfg_target = '0;
        cfg_timeout = '0; start = 0; abort = 0; din = 0; din_valid = 0;
        model_reset();
        #12;
        checkValue("reset.ready", 32'(cfg_ready),   32'd1);
        checkValue("reset.busy",  32'(busy),        32'd0);
        checkValue("reset.cnt",   32'(match_cnt),   32'd0);
        checkValue("reset.done",  32'(done),        32'd0);
        checkValue("reset.tmo",   32'(timeout),     32'd0);
        checkValue("reset.pulse", 32'(match_pulse), 32'd0);
        @(posedge clk); #1; rst_n = 1;

        // Basic single-hit run: pattern 10111, len 5, target 1
        cfg_pattern = 8'h17; cfg_len = 4'd5; cfg_target = 8'd1; cfg_timeout = 16'd0;
        vecs[0] = mkVec(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1);
        vecs[1] = mkVec(0, 1, 0, 0, 0,  0, 0, 0, 0, 1, 0);
        vecs[2] = mkVec(0, 0, 0, 1, 1,  0, 0, 0, 0, 1, 0);
        vecs[3] = mkVec(0, 0, 0, 0, 1,  0, 0, 0, 0, 1, 0);
        vecs[4] = mkVec(0, 0, 0, 1, 1,  0, 0, 0, 0, 1, 0);
        vecs[5] = mkVec(0, 0, 0, 1, 1,  0, 0, 0, 0, 1, 0);
        vecs[6] = mkVec(0, 0, 0, 1, 1,  1, 1, 1, 0, 0, 0);
        vecs[7] = mkVec(0, 0, 0, 0, 0,  0, 1, 1, 0, 0, 0);
        vecs[8] = mkVec(0, 0, 1, 0, 0,  0, 1, 0, 0, 0, 1);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i], "vec");
            checkValue("vec.pulse", 32'(match_pulse), 32'(vecs[i].exp_pulse));
            checkValue("vec.cnt",   32'(match_cnt),   32'(vecs[i].exp_cnt));
            checkValue("vec.done",  32'(done),        32'(vecs[i].exp_done));
            checkValue("vec.tmo",   32'(timeout),     32'(vecs[i].exp_to));
            checkValue("vec.busy",  32'(busy),        32'(vecs[i].exp_busy));
            checkValue("vec.ready", 32'(cfg_ready),   32'(vecs[i].exp_ready));
        end

        // Back-to-back patterns: overlap decides whether the second one counts
        configure(8'h17, 4'd5, 8'd2, 16'd0, 0);
        arm();
        sendBits(16'b1_0111_0111, 9);
        checkValue("ovl.cnt",  32'(match_cnt), OVERLAP ? 32'd2 : 32'd1);
        checkValue("ovl.done", 32'(done),      OVERLAP ? 32'd1 : 32'd0);
        doAbort();

        // Window expiry 20 cycles after the only hit, then re-arm from TMO
        configure(8'b101, 4'd3, 8'd3, 16'd20, 0);
        arm();
        sendBits(16'b101, 3);
        idle(19);
        checkValue("tmo.early", 32'(timeout), 32'd0);
        idle(1);
        checkValue("tmo.flag",  32'(timeout),   32'd1);
        checkValue("tmo.cnt",   32'(match_cnt), 32'd1);
        checkValue("tmo.ready", 32'(cfg_ready), 32'd0);
        idle(3);
        arm();
        checkValue("tmo.rearm", 32'(busy),    32'd1);
        checkValue("tmo.clear", 32'(timeout), 32'd0);
        doAbort();

        // Hit on the very edge the window would expire: hit wins
        configure(8'b101, 4'd3, 8'd3, 16'd6, 0);
        arm();
        idle(3);
        sendBits(16'b101, 3);
        checkValue("race.cnt", 32'(match_cnt), 32'd1);
        checkValue("race.tmo", 32'(timeout),   32'd0);
        idle(4);
        arm();
        checkValue("race.start_ignored", 32'(match_cnt), 32'd1);
        checkValue("race.tmo5", 32'(timeout), 32'd0);
        idle(1);
        checkValue("race.tmo6", 32'(timeout), 32'd1);
        doAbort();

        // Abort mid-run with din_valid gaps, then config+start together with len 0
        configure(8'h17, 4'd5, 8'd2, 16'd0, 0);
        arm();
        sendBits(16'b10111, 5);
        sendBits(16'b1, 1); idle(2); sendBits(16'b0, 1); idle(1);
        checkValue("abort.ready_armed", 32'(cfg_ready), 32'd0);
        doAbort();
        checkValue("abort.ready", 32'(cfg_ready),   32'd1);
        checkValue("abort.cnt",   32'(match_cnt),   32'd1);
        checkValue("abort.pulse", 32'(match_pulse), 32'd0);
        configure(8'b10, 4'd0, 8'd1, 16'd0, 1);
        sendBits(16'b10, 2);
        checkValue("clamp.cnt",  32'(match_cnt), 32'd1);
        checkValue("clamp.done", 32'(done),      32'd1);
        doAbort();

        // Asynchronous reset mid-run
        configure(8'h17, 4'd5, 8'd2, 16'd0, 0);
        arm();
        sendBits(16'b10111, 5);
        sendBits(16'b101, 3);
        rst_n = 0;
        #1;
        model_reset();
        checkValue("arst.cnt",   32'(match_cnt), 32'd0);
        checkValue("arst.busy",  32'(busy),      32'd0);
        checkValue("arst.ready", 32'(cfg_ready), 32'd1);
        @(posedge clk); #1; rst_n = 1;
        sendBits(16'b11, 2);
        checkValue("arst.nohit", 32'(match_cnt), 32'd0);
        arm();
        sendBits(16'b00, 2);
        checkValue("arst.defcfg", 32'(done), 32'd1);
        doAbort();

        // Randomized traffic against the reference model
        for (int r = 0; r < 8; r++) begin
            configure(8'($urandom), 4'($urandom_range(0, 5)), 8'($urandom_range(0, 4)),
                      ($urandom_range(0, 1) == 1) ? 16'($urandom_range(3, 25)) : 16'd0, 0);
            arm();
            for (int c = 0; c < 200; c++) begin
                cfg_valid   = ($urandom_range(0, 99) < 3);
                cfg_pattern = 8'($urandom);
                cfg_len     = 4'($urandom_range(0, 9));
                cfg_target  = 8'($urandom_range(0, 3));
                cfg_timeout = 16'($urandom_range(0, 20));
                start       = ($urandom_range(0, 99) < 4);
                abort       = ($urandom_range(0, 99) < 1);
                din         = 1'($urandom);
                din_valid   = ($urandom_range(0, 99) < 70);
                tick("rand");
            end
            cfg_valid = 0; start = 0; din_valid = 0;
            doAbort();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
